// File: rtl/z80_bus_sequencer.sv
// z80_bus_sequencer
// Frame sequencer between the Z80 core and the tile's 8-bit pin budget.
// Each 4-cycle frame issues one CPU clock enable (unless stalled), snapshots
// the CPU address/control buses at the frame boundary and time-multiplexes
// the snapshot onto pin_out. Also tracks consecutive stalled frames and
// drives the data-bus output enable with a one-frame write turnaround.
//
// Optional feature macro: Z80_SEQ_WAIT_SYNC_EN
//   defined   -> stall_n passes through a two-flop synchroniser before the
//                frame-boundary sample (adds 2 clk of stall latency).
//   undefined -> stall_n is sampled directly and must be synchronous to clk.

module z80_bus_sequencer #(
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   stall_n,
    input  logic [7:0]             cpu_ctrl,
    input  logic [15:0]            cpu_addr,
    output logic                   cpu_cen,
    output logic [1:0]             phase,
    output logic [7:0]             pin_out,
    output logic [7:0]             data_oe,
    output logic                   frame_stb,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    phase_e                   phase_r;
    phase_e                   phase_nxt_s;
    logic [7:0]               snap_ctrl_r;
    logic [15:0]              snap_addr_r;
    logic                     snap_wr_prev_r;
    logic                     frame_stalled_r;
    logic [STALL_CNT_W-1:0]   stall_cnt_r;
    logic                     stall_sample_s;
    logic                     frame_end_s;
    logic [7:0]               pin_mux_s;

`ifdef Z80_SEQ_WAIT_SYNC_EN
    logic                     stall_sync1_r;
    logic                     stall_sync2_r;

    // Two-flop synchroniser for the asynchronous stall request; runs every clk independent of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_sync1_r <= 1'b1;
            stall_sync2_r <= 1'b1;
        end else begin
            stall_sync1_r <= stall_n;
            stall_sync2_r <= stall_sync1_r;
        end
    end

    assign stall_sample_s = stall_sync2_r;
`else
    assign stall_sample_s = stall_n;
`endif

    // The frame boundary is the enabled edge leaving phase 3.
    assign frame_end_s = ena & (phase_r == PH3);

    // Phase state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PH0;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Next phase: advance 0->1->2->3->0 while enabled, hold otherwise.
    always_comb begin
        phase_nxt_s = phase_r;
        if (ena) begin
            case (phase_r)
                PH0:     phase_nxt_s = PH1;
                PH1:     phase_nxt_s = PH2;
                PH2:     phase_nxt_s = PH3;
                PH3:     phase_nxt_s = PH0;
                default: phase_nxt_s = PH0;
            endcase
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Frame-boundary snapshot of CPU buses, write history and stall state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_ctrl_r     <= 8'hFF;
            snap_addr_r     <= 16'h0000;
            snap_wr_prev_r  <= 1'b1;
            frame_stalled_r <= 1'b0;
        end else if (frame_end_s) begin
            snap_ctrl_r     <= cpu_ctrl;
            snap_addr_r     <= cpu_addr;
            snap_wr_prev_r  <= snap_ctrl_r[4];
            frame_stalled_r <= ~stall_sample_s;
        end
    end

    // Saturating count of consecutive stalled frames; any unstalled frame clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (frame_end_s) begin
            if (!stall_sample_s) begin
                if (stall_cnt_r != {STALL_CNT_W{1'b1}}) begin
                    stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                stall_cnt_r <= {STALL_CNT_W{1'b0}};
            end
        end
    end

    // Pin multiplexer: control byte twice per frame, address low then high.
    always_comb begin
        pin_mux_s = snap_ctrl_r;
        case (phase_r)
            PH0:     pin_mux_s = snap_ctrl_r;
            PH1:     pin_mux_s = snap_addr_r[7:0];
            PH2:     pin_mux_s = snap_ctrl_r;
            PH3:     pin_mux_s = snap_addr_r[15:8];
            default: pin_mux_s = snap_ctrl_r;
        endcase
    end

    assign pin_out   = pin_mux_s;
    assign phase     = phase_r;
    assign cpu_cen   = (phase_r == PH0) & ena & ~frame_stalled_r;
    assign frame_stb = (phase_r == PH0) & ena;
    // Drive the data pins only after two consecutive write snapshots.
    assign data_oe   = {8{~snap_ctrl_r[4] & ~snap_wr_prev_r}};
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_z80_bus_sequencer.sv
// Scoreboard bench for z80_bus_sequencer (default build, no stall synchroniser).
// The driver pushes a hand-computed expectation for each applied vector; a
// separate monitor pops and compares on the falling clock edge.

module tb_z80_bus_sequencer;

    typedef struct {
        int          id;
        logic [1:0]  ph;
        logic [7:0]  pin;
        logic [7:0]  oe;
        logic        cen;
        logic        stb;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        stall_n;
    logic [7:0]  cpu_ctrl;
    logic [15:0] cpu_addr;
    logic        cpu_cen;
    logic [1:0]  phase;
    logic [7:0]  pin_out;
    logic [7:0]  data_oe;
    logic        frame_stb;
    logic [7:0]  stall_cnt;

    exp_t        sb_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_push = 0;
    logic        chk_tog = 1'b0;

    z80_bus_sequencer #(.STALL_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .stall_n   (stall_n),
        .cpu_ctrl  (cpu_ctrl),
        .cpu_addr  (cpu_addr),
        .cpu_cen   (cpu_cen),
        .phase     (phase),
        .pin_out   (pin_out),
        .data_oe   (data_oe),
        .frame_stb (frame_stb),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clk or chk_tog);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                n_vec++;
                if (phase !== e.ph || pin_out !== e.pin || data_oe !== e.oe ||
                    cpu_cen !== e.cen || frame_stb !== e.stb || stall_cnt !== e.cnt) begin
                    n_miss++;
                    $display("FAIL vec%0d: got ph=%0d pin=%h oe=%h cen=%b stb=%b cnt=%0d, want ph=%0d pin=%h oe=%h cen=%b stb=%b cnt=%0d",
                             e.id, phase, pin_out, data_oe, cpu_cen, frame_stb, stall_cnt,
                             e.ph, e.pin, e.oe, e.cen, e.stb, e.cnt);
                end
            end
        end
    end

    task automatic push(input logic [1:0] ph, input logic [7:0] pin, input logic [7:0] oe,
                        input logic cen, input logic stb, input logic [7:0] cnt);
        exp_t e;
        e.id = n_push; e.ph = ph; e.pin = pin; e.oe = oe;
        e.cen = cen; e.stb = stb; e.cnt = cnt;
        sb_q.push_back(e);
        n_push++;
    endtask

    // One clock: apply inputs just after the edge, expect the state that edge produced.
    task automatic step(input logic en, input logic sn, input logic [7:0] ci, input logic [15:0] ai,
                        input logic [1:0] ph, input logic [7:0] pin, input logic [7:0] oe,
                        input logic cen, input logic stb, input logic [7:0] cnt);
        @(posedge clk);
        #1;
        ena = en; stall_n = sn; cpu_ctrl = ci; cpu_addr = ai;
        push(ph, pin, oe, cen, stb, cnt);
    endtask

    // One full enabled frame (phases 0..3) whose snapshot is ec/ea; inputs are sampled at its end.
    task automatic frame(input logic sn, input logic [7:0] ci, input logic [15:0] ai,
                         input logic [7:0] ec, input logic [15:0] ea, input logic [7:0] oe,
                         input logic cen, input logic [7:0] cnt);
        step(1'b1, sn, ci, ai, 2'd0, ec,        oe, cen,  1'b1, cnt);
        step(1'b1, sn, ci, ai, 2'd1, ea[7:0],   oe, 1'b0, 1'b0, cnt);
        step(1'b1, sn, ci, ai, 2'd2, ec,        oe, 1'b0, 1'b0, cnt);
        step(1'b1, sn, ci, ai, 2'd3, ea[15:8],  oe, 1'b0, 1'b0, cnt);
    endtask

    // Directed stimulus.
    initial begin
        rst_n = 1'b0; ena = 1'b1; stall_n = 1'b1; cpu_ctrl = 8'hA5; cpu_addr = 16'h1234;
        push(2'd0, 8'hFF, 8'h00, 1'b1, 1'b1, 8'd0);
        #12 rst_n = 1'b1;

        // Remainder of the first (pre-snapshot) frame.
        step(1'b1, 1'b1, 8'hA5, 16'h1234, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'hA5, 16'h1234, 2'd2, 8'hFF, 8'h00, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'hA5, 16'h1234, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);

        // Basic multiplexing, then two stalled frames, then recovery.
        frame(1'b1, 8'hA5, 16'h1234, 8'hA5, 16'h1234, 8'h00, 1'b1, 8'd0);
        frame(1'b0, 8'hA5, 16'h1234, 8'hA5, 16'h1234, 8'hFF, 1'b1, 8'd0);
        frame(1'b0, 8'hA5, 16'h1234, 8'hA5, 16'h1234, 8'hFF, 1'b0, 8'd1);
        frame(1'b1, 8'hA5, 16'h1234, 8'hA5, 16'h1234, 8'hFF, 1'b0, 8'd2);
        frame(1'b1, 8'hFF, 16'hBEEF, 8'hA5, 16'h1234, 8'hFF, 1'b1, 8'd0);

        // Write turnaround: wr_n low in three snapshots, then high.
        frame(1'b1, 8'hEF, 16'h0102, 8'hFF, 16'hBEEF, 8'h00, 1'b1, 8'd0);
        frame(1'b1, 8'hEF, 16'h0102, 8'hEF, 16'h0102, 8'h00, 1'b1, 8'd0);
        frame(1'b1, 8'hEF, 16'h0102, 8'hEF, 16'h0102, 8'hFF, 1'b1, 8'd0);
        frame(1'b1, 8'hFF, 16'h0304, 8'hEF, 16'h0102, 8'hFF, 1'b1, 8'd0);
        frame(1'b1, 8'hFF, 16'h0304, 8'hFF, 16'h0304, 8'h00, 1'b1, 8'd0);

        // ena low for 5 clk in phase 2; stall_n wiggles while frozen.
        step(1'b1, 1'b1, 8'hFF, 16'h0304, 2'd0, 8'hFF, 8'h00, 1'b1, 1'b1, 8'd0);
        step(1'b1, 1'b1, 8'hFF, 16'h0304, 2'd1, 8'h04, 8'h00, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'hFF, 16'h0304, 2'd2, 8'hFF, 8'h00, 1'b0, 1'b0, 8'd0);
        end
        step(1'b1, 1'b1, 8'hFF, 16'h0304, 2'd2, 8'hFF, 8'h00, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'hFF, 16'h0304, 2'd3, 8'h03, 8'h00, 1'b0, 1'b0, 8'd0);

        // Build stall_cnt up to 3, then reset asynchronously in phase 1.
        frame(1'b0, 8'hFF, 16'h0304, 8'hFF, 16'h0304, 8'h00, 1'b1, 8'd0);
        frame(1'b0, 8'hFF, 16'h0304, 8'hFF, 16'h0304, 8'h00, 1'b0, 8'd1);
        frame(1'b0, 8'hFF, 16'h0304, 8'hFF, 16'h0304, 8'h00, 1'b0, 8'd2);
        step(1'b1, 1'b0, 8'hFF, 16'h0304, 2'd0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'd3);
        step(1'b1, 1'b0, 8'hA5, 16'h1234, 2'd1, 8'h04, 8'h00, 1'b0, 1'b0, 8'd3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        push(2'd0, 8'hFF, 8'h00, 1'b1, 1'b1, 8'd0);
        chk_tog = ~chk_tog;
        #1 rst_n = 1'b1;

        // Long stall: saturate at 255, then release.
        step(1'b1, 1'b0, 8'hA5, 16'h1234, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'hA5, 16'h1234, 2'd2, 8'hFF, 8'h00, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'hA5, 16'h1234, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
        for (int k = 1; k <= 300; k++) begin
            frame((k == 300) ? 1'b1 : 1'b0, 8'hA5, 16'h1234, 8'hA5, 16'h1234,
                  (k == 1) ? 8'h00 : 8'hFF, 1'b0, (k > 255) ? 8'd255 : 8'(k));
        end
        frame(1'b1, 8'hA5, 16'h1234, 8'hA5, 16'h1234, 8'hFF, 1'b1, 8'd0);

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 5 && sb_q.size() > 0; w++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/z80_bus_sequencer.md
# z80_bus_sequencer

Frame sequencer between the Z80 core and the 8-bit pin budget of the tile. Divides the tile clock into 4-cycle frames, issues the single-cycle CPU clock enable, snapshots the CPU address and control buses once per frame, and time-multiplexes them onto the output pins. Also handles external stall requests (wait-state frames) and drives the data-bus output enable with a write turnaround guard.

## Interface
Parameters:
- STALL_CNT_W, 8: width of the saturating consecutive-stall counter.

Ports:
- clk  input  1  tile clock
- rst_n  input  1  reset; asynchronous, active-low
- ena  input  1  global enable; low freezes all sequencing
- stall_n  input  1  external stall request, active-low
- cpu_ctrl  input  8  CPU controls {busak_n, halt_n, rfsh_n, wr_n, rd_n, iorq_n, mreq_n, m1_n}
- cpu_addr  input  16  CPU address bus
- cpu_cen  output  1  CPU clock enable, one-cycle pulse per non-stalled frame
- phase  output  2  current frame phase 0..3
- pin_out  output  8  multiplexed pin bus
- data_oe  output  8  data pin output enable (1 = output)
- frame_stb  output  1  one-cycle pulse in phase 0 of every frame
- stall_cnt  output  STALL_CNT_W  consecutive stalled frames, saturating

## Operation
- Phase counter advances 0→1→2→3→0 on each clk with ena=1; holds while ena=0.
- Snapshot: on the edge leaving phase 3 (ena=1), snap_ctrl←cpu_ctrl, snap_addr←cpu_addr, snap_wr_prev←previous snap_ctrl[4].
- pin_out (combinational from registers): phase 0 and 2 → snap_ctrl; phase 1 → snap_addr[7:0]; phase 3 → snap_addr[15:8].
- Stall: stall sample (raw stall_n, or synchronised, see Configuration) is registered as frame_stalled on the edge leaving phase 3.
- cpu_cen = (phase==0) & ena & ~frame_stalled. The CPU advances on the edge ending phase 0; outputs settle over phases 1–3 and are captured by the next snapshot.
- stall_cnt: on the edge leaving phase 3, stall sampled low → increment, saturating at all-ones; sampled high → clear to 0.
- data_oe = {8{~snap_ctrl[4] & ~snap_wr_prev}}: asserted only after wr_n is low in two consecutive snapshots (one-frame turnaround); deasserted as soon as one snapshot has wr_n=1.
- frame_stb = (phase==0) & ena, issued regardless of stall.

## Timing
- Reset values: phase=0, snap_ctrl=8'hFF, snap_addr=16'h0000, snap_wr_prev=1, frame_stalled=0, stall_cnt=0, synchroniser flops=1. Hence pin_out=8'hFF, data_oe=0. cpu_cen=1 and frame_stb=1 if ena=1 during reset release (phase 0).
- cpu_cen period: 4 clk with no stalls; each stalled frame adds 4 clk.
- Stall latency (without macro): stall_n low at the edge leaving phase 3 suppresses cpu_cen in the immediately following phase 0.
- ena deasserted mid-frame: phase, snapshots, stall state and counter hold; pin_out and data_oe keep their values; cpu_cen and frame_stb are 0. Operation resumes at the held phase.
- stall_n changes outside the phase-3 sample point have no effect.
- Reset mid-frame: all state returns to reset values immediately and asynchronously; the partial frame is discarded.
- stall_cnt at max with stall still low: holds at max; no wrap.

## Configuration
- Z80_SEQ_WAIT_SYNC_EN defined: stall_n passes through a two-flop synchroniser (reset to 1, clocked every clk regardless of ena) before the phase-3 sample. Stall latency grows by 2 clk. stall_n must be stable ≥3 clk before the sample edge.
- Undefined: stall_n sampled directly. The source must be synchronous to clk.

## Test plan
- Reset, ena=1, stall_n=1, cpu_ctrl=8'hA5, cpu_addr=16'h1234 → after the first snapshot, pin_out sequence per frame is A5,34,A5,12; cpu_cen pulses every 4 clk in phase 0.
- stall_n held low across two phase-3 samples → two consecutive frames with cpu_cen=0, frame_stb still pulsing, stall_cnt=2; stall_n=1 at next sample → stall_cnt=0, cpu_cen resumes.
- cpu_ctrl[4] goes low for three frames, then high → data_oe=8'h00 in frame 1, 8'hFF in frames 2–3, 8'h00 in the first frame whose snapshot has wr_n=1.
- ena dropped for 5 clk during phase 2 → phase stays 2, pin_out stays snap_ctrl, cpu_cen=0; after ena=1 sequence continues 3,0 with cpu_cen at phase 0.
- rst_n asserted during phase 1 with stall_cnt=3 → pin_out=8'hFF, data_oe=0, phase=0, stall_cnt=0 without waiting for a clk edge.
- stall_n low for 300 frames → stall_cnt saturates at 255 and holds. With Z80_SEQ_WAIT_SYNC_EN, a stall_n low applied 1 clk before a sample edge is not seen until the next frame.
